bus_bridge_gen: RTL and testbench

Parametrised CPU-to-peripheral bridge for the system bus. It decodes a uniform address window into NUM_DEV equal device slots plus one internal control slot. Each access runs a request/ready handshake, so devices may stall, and a bus timeout answers any device that never acknowledges. It also synchronises and masks device interrupts onto HWInt. It sits between the CPU's Pr* bus port and the Timer, UART, switch, LED, tube and button devices.

---
 rtl/bus_bridge_gen.sv | 222 ++++++++++++++++++++++
 tb/tb_bus_bridge_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_bridge_gen.sv
`default_nettype none
// ============================================================================
// Module   : bus_bridge_gen
// Brief    : CPU-to-peripheral bridge with slot decode, request/ready device
//            handshake, bus timeout, and masked interrupt routing to HWInt.
// Revision : 1.0 - initial release
// ============================================================================
module bus_bridge_gen #(
    parameter int          NUM_DEV   = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int          SPAN_LOG2 = 4,
    parameter int          TIMEOUT   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    PrReq,
    input  logic                    PrWe,
    input  logic [31:0]             PrAddr,
    input  logic [31:0]             PrWD,
    output logic [31:0]             PrRD,
    output logic                    PrReady,
    output logic                    PrErr,
    output logic [5:0]              HWInt,
    output logic [NUM_DEV-1:0]      dev_sel,
    output logic                    dev_we,
    output logic [SPAN_LOG2-1:0]    dev_addr,
    output logic [31:0]             dev_wd,
    input  logic [32*NUM_DEV-1:0]   dev_rd,
    input  logic [NUM_DEV-1:0]      dev_ack,
    input  logic [NUM_DEV-1:0]      dev_irq
);

    localparam int                   c_CNT_W       = $clog2(TIMEOUT);
    localparam logic [c_CNT_W-1:0]   c_CNT_LAST    = c_CNT_W'(TIMEOUT - 1);
    localparam logic [SPAN_LOG2-1:0] c_OFF_IMASK   = SPAN_LOG2'(0);
    localparam logic [SPAN_LOG2-1:0] c_OFF_IPEND   = SPAN_LOG2'(4);
    localparam logic [SPAN_LOG2-1:0] c_OFF_ERRADDR = SPAN_LOG2'(8);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                 r_state_q,   w_state_d;
    logic [NUM_DEV-1:0]     r_sel_q,     w_sel_d;
    logic [SPAN_LOG2-1:0]   r_offset_q,  w_offset_d;
    logic [31:0]            r_wd_q,      w_wd_d;
    logic                   r_we_q,      w_we_d;
    logic [31:0]            r_addr_q,    w_addr_d;
    logic [c_CNT_W-1:0]     r_cnt_q,     w_cnt_d;
    logic [31:0]            r_prrd_q,    w_prrd_d;
    logic                   r_prerr_q,   w_prerr_d;
    logic [NUM_DEV-1:0]     r_imask_q,   w_imask_d;
    logic [31:0]            r_erraddr_q, w_erraddr_d;
    logic [NUM_DEV-1:0]     r_irq_q;
    logic [5:0]             r_hwint_q,   w_hwint_d;

    logic [31:0]            w_off;
    logic [31:0]            w_idx;
    logic [SPAN_LOG2-1:0]   w_off_lo;
    logic                   w_invalid;
    logic                   w_internal;
    logic [NUM_DEV-1:0]     w_oh;
    logic [31:0]            w_int_rdata;
    logic [31:0]            w_dev_rdata;
    logic                   w_ack;

    // Address decode: slot index past NUM_DEV is out of window.
    assign w_off      = PrAddr - BASE_ADDR;
    assign w_idx      = w_off >> SPAN_LOG2;
    assign w_off_lo   = w_off[SPAN_LOG2-1:0];
    assign w_invalid  = (PrAddr < BASE_ADDR) || (w_idx > 32'(NUM_DEV)) || (PrAddr[1:0] != 2'b00);
    assign w_internal = (w_idx == 32'(NUM_DEV));

    always_comb begin
        w_oh = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            w_oh[i] = (w_idx == 32'(i));
        end
    end

    always_comb begin
        w_int_rdata = '0;
        if (w_off_lo == c_OFF_IMASK) begin
            w_int_rdata = 32'(r_imask_q);
        end else if (w_off_lo == c_OFF_IPEND) begin
            w_int_rdata = 32'(r_irq_q);
        end else if (w_off_lo == c_OFF_ERRADDR) begin
            w_int_rdata = r_erraddr_q;
        end
    end

    always_comb begin
        w_dev_rdata = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (r_sel_q[i]) begin
                w_dev_rdata = w_dev_rdata | dev_rd[32*i +: 32];
            end
        end
    end

    assign w_ack = |(dev_ack & r_sel_q);

    always_comb begin
        w_state_d   = r_state_q;
        w_sel_d     = r_sel_q;
        w_offset_d  = r_offset_q;
        w_wd_d      = r_wd_q;
        w_we_d      = r_we_q;
        w_addr_d    = r_addr_q;
        w_cnt_d     = r_cnt_q;
        w_prrd_d    = r_prrd_q;
        w_prerr_d   = r_prerr_q;
        w_imask_d   = r_imask_q;
        w_erraddr_d = r_erraddr_q;

        case (r_state_q)
            S_IDLE: begin
                if (PrReq) begin
                    if (w_invalid) begin
                        w_erraddr_d = PrAddr;
                        w_prrd_d    = '1;
                        w_prerr_d   = 1'b1;
                        w_state_d   = S_RESP;
                    end else if (w_internal) begin
                        w_prerr_d = 1'b0;
                        w_state_d = S_RESP;
                        if (PrWe) begin
                            w_prrd_d = '0;
                            if (w_off_lo == c_OFF_IMASK) begin
                                w_imask_d = PrWD[NUM_DEV-1:0];
                            end
                        end else begin
                            w_prrd_d = w_int_rdata;
                        end
                    end else begin
                        w_sel_d    = w_oh;
                        w_offset_d = w_off_lo;
                        w_wd_d     = PrWD;
                        w_we_d     = PrWe;
                        w_addr_d   = PrAddr;
                        w_cnt_d    = '0;
                        w_state_d  = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                // An ack on the final permitted cycle still completes normally.
                if (w_ack) begin
                    w_prrd_d  = r_we_q ? 32'h0 : w_dev_rdata;
                    w_prerr_d = 1'b0;
                    w_state_d = S_RESP;
                end else if (r_cnt_q == c_CNT_LAST) begin
                    w_prrd_d    = '1;
                    w_erraddr_d = r_addr_q;
                    w_prerr_d   = 1'b1;
                    w_state_d   = S_RESP;
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    for (genvar gi = 0; gi < 6; gi++) begin : g_hwint
        if (gi < NUM_DEV) begin : g_used
            assign w_hwint_d[gi] = r_irq_q[gi] & r_imask_q[gi];
        end else begin : g_unused
            assign w_hwint_d[gi] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state_q   <= S_IDLE;
            r_sel_q     <= '0;
            r_offset_q  <= '0;
            r_wd_q      <= '0;
            r_we_q      <= 1'b0;
            r_addr_q    <= '0;
            r_cnt_q     <= '0;
            r_prrd_q    <= '0;
            r_prerr_q   <= 1'b0;
            r_imask_q   <= '1;
            r_erraddr_q <= '0;
            r_irq_q     <= '0;
            r_hwint_q   <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_sel_q     <= w_sel_d;
            r_offset_q  <= w_offset_d;
            r_wd_q      <= w_wd_d;
            r_we_q      <= w_we_d;
            r_addr_q    <= w_addr_d;
            r_cnt_q     <= w_cnt_d;
            r_prrd_q    <= w_prrd_d;
            r_prerr_q   <= w_prerr_d;
            r_imask_q   <= w_imask_d;
            r_erraddr_q <= w_erraddr_d;
            r_irq_q     <= dev_irq;
            r_hwint_q   <= w_hwint_d;
        end
    end

    assign PrRD     = r_prrd_q;
    assign PrReady  = (r_state_q == S_RESP);
    assign PrErr    = r_prerr_q;
    assign HWInt    = r_hwint_q;
    assign dev_sel  = (r_state_q == S_ACCESS) ? r_sel_q : '0;
    assign dev_we   = (r_state_q == S_ACCESS) & r_we_q;
    assign dev_addr = r_offset_q;
    assign dev_wd   = r_wd_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_bridge_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_bridge_gen
// Brief    : Directed table-driven bench for bus_bridge_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_bridge_gen;

    localparam int NUM_DEV = 6;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  PrReq;
    logic                  PrWe;
    logic [31:0]           PrAddr;
    logic [31:0]           PrWD;
    logic [31:0]           PrRD;
    logic                  PrReady;
    logic                  PrErr;
    logic [5:0]            HWInt;
    logic [NUM_DEV-1:0]    dev_sel;
    logic                  dev_we;
    logic [3:0]            dev_addr;
    logic [31:0]           dev_wd;
    logic [32*NUM_DEV-1:0] dev_rd;
    logic [NUM_DEV-1:0]    dev_ack;
    logic [NUM_DEV-1:0]    dev_irq;

    always #5 clk = ~clk;

    bus_bridge_gen #(
        .NUM_DEV   (NUM_DEV),
        .BASE_ADDR (32'h0000_7F00),
        .SPAN_LOG2 (4),
        .TIMEOUT   (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .PrReq    (PrReq),
        .PrWe     (PrWe),
        .PrAddr   (PrAddr),
        .PrWD     (PrWD),
        .PrRD     (PrRD),
        .PrReady  (PrReady),
        .PrErr    (PrErr),
        .HWInt    (HWInt),
        .dev_sel  (dev_sel),
        .dev_we   (dev_we),
        .dev_addr (dev_addr),
        .dev_wd   (dev_wd),
        .dev_rd   (dev_rd),
        .dev_ack  (dev_ack),
        .dev_irq  (dev_irq)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wd;
        int          ack_dly;     // -1: device never acks
        logic [31:0] rdv;
        int          exp_lat;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [5:0]  exp_sel;
        int          exp_selcyc;
        logic [3:0]  exp_daddr;
    } vec_t;

    vec_t vecs[18];
    int   n_checks = 0;
    int   n_errs   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Runs one bus access with a bench-side device model; starts and ends 1 unit after a clk edge.
    task automatic do_access(
        input  logic [31:0] addr, input logic we, input logic [31:0] wd,
        input  int ack_dly, input logic [31:0] rdv,
        output int lat, output logic [31:0] rd, output logic err,
        output logic [5:0] sel_seen, output int selcyc, output int nready,
        output logic [3:0] daddr, output logic we_seen, output logic [31:0] wd_seen,
        output logic held_ok);
        int post;
        lat = -1; rd = '0; err = 1'b0; sel_seen = '0; selcyc = 0; nready = 0;
        daddr = '0; we_seen = 1'b0; wd_seen = '0; held_ok = 1'b1; post = 0;
        PrAddr = addr; PrWe = we; PrWD = wd; PrReq = 1'b1;
        for (int c = 1; c <= 40 && post < 3; c++) begin
            @(posedge clk); #1;
            dev_ack = '0;
            if (dev_sel != '0) begin
                selcyc++;
                sel_seen = sel_seen | dev_sel;
                if (selcyc == 1) begin
                    daddr = dev_addr; we_seen = dev_we; wd_seen = dev_wd;
                end else if (dev_addr !== daddr || dev_we !== we_seen || dev_wd !== wd_seen) begin
                    held_ok = 1'b0;
                end
                for (int i = 0; i < NUM_DEV; i++) begin
                    dev_rd[32*i +: 32] = dev_sel[i] ? rdv : (32'hD0D0_0000 | 32'(i));
                end
                if (ack_dly >= 0 && selcyc == ack_dly + 1) dev_ack = dev_sel;
            end
            if (PrReady) begin
                nready++;
                if (lat < 0) begin
                    lat = c; rd = PrRD; err = PrErr; PrReq = 1'b0;
                end
            end
            if (lat >= 0) post++;
        end
        PrReq   = 1'b0;
        dev_ack = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, selcyc, nready, rcnt;
        logic [31:0] rd, wd_seen;
        logic        err, we_seen, held_ok;
        logic [5:0]  sel_seen;
        logic [3:0]  daddr;

        //          addr          we    wd            ack rdv           lat chk   exp_rd        err   sel        cyc daddr
        vecs[0]  = '{32'h7F14, 1'b0, 32'h0,        0, 32'h12345678, 2, 1'b1, 32'h12345678, 1'b0, 6'b000010, 1, 4'h4};
        vecs[1]  = '{32'h7F30, 1'b1, 32'hA5,       3, 32'h77777777, 5, 1'b1, 32'h0,        1'b0, 6'b001000, 4, 4'h0};
        vecs[2]  = '{32'h7F00, 1'b0, 32'h0,       -1, 32'h11111111,17, 1'b1, 32'hFFFFFFFF, 1'b1, 6'b000001,16, 4'h0};
        vecs[3]  = '{32'h7F68, 1'b0, 32'h0,       -1, 32'h0,        1, 1'b1, 32'h7F00,     1'b0, 6'b000000, 0, 4'h0};
        vecs[4]  = '{32'h7F80, 1'b0, 32'h0,       -1, 32'h0,        1, 1'b1, 32'hFFFFFFFF, 1'b1, 6'b000000, 0, 4'h0};
        vecs[5]  = '{32'h7F02, 1'b0, 32'h0,       -1, 32'h0,        1, 1'b1, 32'hFFFFFFFF, 1'b1, 6'b000000, 0, 4'h0};
        vecs[6]  = '{32'h7F68, 1'b0, 32'h0,       -1, 32'h0,        1, 1'b1, 32'h7F02,     1'b0, 6'b000000, 0, 4'h0};
        vecs[7]  = '{32'h7F5C, 1'b0, 32'h0,        1, 32'hCAFEF00D, 3, 1'b1, 32'hCAFEF00D, 1'b0, 6'b100000, 2, 4'hC};
        vecs[8]  = '{32'h7EFC, 1'b0, 32'h0,       -1, 32'h0,        1, 1'b1, 32'hFFFFFFFF, 1'b1, 6'b000000, 0, 4'h0};
        vecs[9]  = '{32'h7F68, 1'b1, 32'h1234,    -1, 32'h0,        1, 1'b0, 32'h0,        1'b0, 6'b000000, 0, 4'h0};
        vecs[10] = '{32'h7F68, 1'b0, 32'h0,       -1, 32'h0,        1, 1'b1, 32'h7EFC,     1'b0, 6'b000000, 0, 4'h0};
        vecs[11] = '{32'h7F6C, 1'b0, 32'h0,       -1, 32'h0,        1, 1'b1, 32'h0,        1'b0, 6'b000000, 0, 4'h0};
        vecs[12] = '{32'h7F28, 1'b0, 32'h0,       15, 32'h0BADBEEF,17, 1'b1, 32'h0BADBEEF, 1'b0, 6'b000100,16, 4'h8};
        vecs[13] = '{32'h7F60, 1'b0, 32'h0,       -1, 32'h0,        1, 1'b1, 32'h3F,       1'b0, 6'b000000, 0, 4'h0};
        vecs[14] = '{32'h7F60, 1'b1, 32'hFFFFFF01,-1, 32'h0,        1, 1'b0, 32'h0,        1'b0, 6'b000000, 0, 4'h0};
        vecs[15] = '{32'h7F60, 1'b0, 32'h0,       -1, 32'h0,        1, 1'b1, 32'h01,       1'b0, 6'b000000, 0, 4'h0};
        vecs[16] = '{32'h7F44, 1'b1, 32'h55,       0, 32'h99999999, 2, 1'b1, 32'h0,        1'b0, 6'b010000, 1, 4'h4};
        vecs[17] = '{32'h7F70, 1'b0, 32'h0,       -1, 32'h0,        1, 1'b1, 32'hFFFFFFFF, 1'b1, 6'b000000, 0, 4'h0};

        reset = 1'b0; PrReq = 1'b0; PrWe = 1'b0; PrAddr = '0; PrWD = '0;
        dev_rd = '0; dev_ack = '0; dev_irq = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst PrRD",     PrRD, 32'h0);
        chk("rst PrReady",  32'(PrReady), 32'h0);
        chk("rst PrErr",    32'(PrErr), 32'h0);
        chk("rst HWInt",    32'(HWInt), 32'h0);
        chk("rst dev_sel",  32'(dev_sel), 32'h0);
        chk("rst dev_we",   32'(dev_we), 32'h0);
        chk("rst dev_addr", 32'(dev_addr), 32'h0);
        chk("rst dev_wd",   dev_wd, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 18; k++) begin
            do_access(vecs[k].addr, vecs[k].we, vecs[k].wd, vecs[k].ack_dly, vecs[k].rdv,
                      lat, rd, err, sel_seen, selcyc, nready, daddr, we_seen, wd_seen, held_ok);
            chk($sformatf("v%0d latency", k), 32'(lat), 32'(vecs[k].exp_lat));
            chk($sformatf("v%0d PrErr", k), 32'(err), 32'(vecs[k].exp_err));
            chk($sformatf("v%0d PrReady count", k), 32'(nready), 32'h1);
            chk($sformatf("v%0d dev_sel", k), 32'(sel_seen), 32'(vecs[k].exp_sel));
            chk($sformatf("v%0d sel cycles", k), 32'(selcyc), 32'(vecs[k].exp_selcyc));
            if (vecs[k].chk_rd) chk($sformatf("v%0d PrRD", k), rd, vecs[k].exp_rd);
            if (vecs[k].exp_selcyc > 0) begin
                chk($sformatf("v%0d dev_addr", k), 32'(daddr), 32'(vecs[k].exp_daddr));
                chk($sformatf("v%0d dev_we", k), 32'(we_seen), 32'(vecs[k].we));
                chk($sformatf("v%0d held", k), 32'(held_ok), 32'h1);
                if (vecs[k].we) chk($sformatf("v%0d dev_wd", k), wd_seen, vecs[k].wd);
            end
        end

        // Interrupts with IMASK=0x01: two-cycle latency, level behaviour.
        dev_irq = 6'b000011;
        @(posedge clk); #1;
        chk("irq after 1 cycle", 32'(HWInt), 32'h0);
        @(posedge clk); #1;
        chk("irq after 2 cycles", 32'(HWInt), 32'h01);
        do_access(32'h7F64, 1'b0, 32'h0, -1, 32'h0, lat, rd, err, sel_seen, selcyc, nready,
                  daddr, we_seen, wd_seen, held_ok);
        chk("IPEND read", rd, 32'h03);
        chk("IPEND err", 32'(err), 32'h0);
        dev_irq = 6'b000000;
        repeat (2) @(posedge clk);
        #1;
        chk("irq level drop", 32'(HWInt), 32'h0);
        dev_irq = 6'b000011;

        // Reset in the middle of a stalled device access.
        PrAddr = 32'h7F40; PrWe = 1'b0; PrWD = '0; PrReq = 1'b1;
        @(posedge clk); #1;
        chk("midrst access sel", 32'(dev_sel), 32'h10);
        PrReq = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midrst dev_sel", 32'(dev_sel), 32'h0);
        chk("midrst PrReady", 32'(PrReady), 32'h0);
        chk("midrst PrRD", PrRD, 32'h0);
        reset = 1'b1;
        rcnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (PrReady) rcnt++;
        end
        chk("midrst no PrReady", 32'(rcnt), 32'h0);
        do_access(32'h7F60, 1'b0, 32'h0, -1, 32'h0, lat, rd, err, sel_seen, selcyc, nready,
                  daddr, we_seen, wd_seen, held_ok);
        chk("IMASK after reset", rd, 32'h3F);
        chk("HWInt after reset", 32'(HWInt), 32'h03);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
